// File: rtl/task_enabler_pkg.sv
// -----------------------------------------------------------------------------
// task_enabler_pkg
// Purpose : shared type for the 16-bit per-task enable mask used by the task
//           sequencer (bit 0 = task1 ... bit 15 = task16).
// -----------------------------------------------------------------------------
package task_enabler_pkg;
    typedef logic [15:0] task_enabler;
endpackage

// File: rtl/task_sequencer_if.sv
// -----------------------------------------------------------------------------
// task_sequencer_if
// Purpose : bundles the control and status signals of task_sequencer.
//   enable       : task enable mask, latched when a run starts
//   start/abort  : run request / run termination
//   task_start   : one-hot launch pulse to task i
//   task_done    : per-task completion pulse
//   busy, cur_task, seq_done, done_mask, timeout_mask : run status
// Modports:
//   master : the controller side (drives requests, task completions)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface task_sequencer_if;
    import task_enabler_pkg::*;

    task_enabler enable;
    logic        start;
    logic        abort;
    logic [15:0] task_start;
    logic [15:0] task_done;
    logic        busy;
    logic [3:0]  cur_task;
    logic        seq_done;
    logic [15:0] done_mask;
    logic [15:0] timeout_mask;

    modport master (
        output enable, start, abort, task_done,
        input  task_start, busy, cur_task, seq_done, done_mask, timeout_mask
    );

    modport slave (
        input  enable, start, abort, task_done,
        output task_start, busy, cur_task, seq_done, done_mask, timeout_mask
    );
endinterface

// File: rtl/task_sequencer.sv
// -----------------------------------------------------------------------------
// task_sequencer
// Purpose : walks a latched 16-bit enable mask from index 0 to 15, launching
//           each enabled task with a one-cycle pulse, waiting for its done
//           pulse (or a timeout), then idling GAP_CYCLES before moving on.
//           A run ends with a one-cycle seq_done pulse; abort ends it early.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : task_sequencer_if.slave (enable/start/abort/task_done in,
//           task_start/busy/cur_task/seq_done/done_mask/timeout_mask out)
// Parameters:
//   TIMEOUT_CYCLES : max WAIT cycles per task (1..2^24)
//   GAP_CYCLES     : idle cycles after each task (0 = none)
// -----------------------------------------------------------------------------
module task_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    task_sequencer_if.slave  bus
);
    import task_enabler_pkg::*;

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam int unsigned TIMER_LAST_I = TIMEOUT_CYCLES - 1;
    localparam int unsigned GAP_LAST_I   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_LAST_I[TIMER_W-1:0];
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_LAST_I[GAP_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t             state_q,        state_d;
    logic [3:0]         idx_q,          idx_d;
    logic [TIMER_W-1:0] timer_q,        timer_d;
    logic [GAP_W-1:0]   gap_q,          gap_d;
    task_enabler        run_mask_q,     run_mask_d;
    logic [15:0]        done_mask_q,    done_mask_d;
    logic [15:0]        timeout_mask_q, timeout_mask_d;

    logic last_idx;
    logic cur_done;
    logic timer_expired;

    assign last_idx      = (idx_q == 4'd15);
    // Only the awaited task's done bit matters; every other bit is ignored.
    assign cur_done      = bus.task_done[idx_q];
    assign timer_expired = (timer_q == TIMER_LAST);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        gap_d          = gap_q;
        run_mask_d     = run_mask_q;
        done_mask_d    = done_mask_q;
        timeout_mask_d = timeout_mask_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    run_mask_d     = bus.enable;
                    done_mask_d    = '0;
                    timeout_mask_d = '0;
                    idx_d          = 4'd0;
                    state_d        = S_SCAN;
                end
            end

            S_SCAN: begin
                if (run_mask_q[idx_q]) begin
                    state_d = S_LAUNCH;
                end else if (last_idx) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A done pulse on the final timer cycle wins over the timeout.
                if (cur_done || timer_expired) begin
                    if (cur_done) begin
                        done_mask_d[idx_q] = 1'b1;
                    end else begin
                        timeout_mask_d[idx_q] = 1'b1;
                    end
                    gap_d = '0;
                    if (GAP_CYCLES == 0) begin
                        if (last_idx) begin
                            state_d = S_FINISH;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_SCAN;
                        end
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (last_idx) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SCAN;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above: drop to IDLE and freeze the
        // partial results exactly as they stood.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            idx_d          = idx_q;
            timer_d        = timer_q;
            gap_d          = gap_q;
            run_mask_d     = run_mask_q;
            done_mask_d    = done_mask_q;
            timeout_mask_d = timeout_mask_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= 4'd0;
            timer_q        <= '0;
            gap_q          <= '0;
            run_mask_q     <= '0;
            done_mask_q    <= '0;
            timeout_mask_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            gap_q          <= gap_d;
            run_mask_q     <= run_mask_d;
            done_mask_q    <= done_mask_d;
            timeout_mask_q <= timeout_mask_d;
        end
    end

    // Outputs are decoded purely from registered state so they are glitch-free
    // relative to the inputs and clear immediately on reset.
    assign bus.task_start   = (state_q == S_LAUNCH) ? (16'd1 << idx_q) : 16'd0;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.cur_task     = idx_q;
    assign bus.seq_done     = (state_q == S_FINISH);
    assign bus.done_mask    = done_mask_q;
    assign bus.timeout_mask = timeout_mask_q;

endmodule

// File: tb/tb_task_sequencer.sv
module tb_task_sequencer;
    import task_enabler_pkg::*;

    localparam int T = 10;
    localparam int G = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Per-task response delay (cycles from task_start to task_done).
    int dly[16];

    // Reference model results for one run.
    int          m_launch[16];
    int          m_finish;
    logic [15:0] m_done;
    logic [15:0] m_tmo;
    logic [15:0] last_done;
    logic [15:0] last_tmo;

    task_sequencer_if bus();

    task_sequencer #(
        .TIMEOUT_CYCLES(T),
        .GAP_CYCLES    (G)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Timeline model. Cycle 0 is the cycle in which start is sampled.
    // Each index is scanned for one cycle; an enabled index then spends one
    // LAUNCH cycle, min(delay, T) WAIT cycles and G GAP cycles. The run's
    // FINISH cycle follows index 15. Abort in cycle a cancels everything that
    // would have happened after cycle a.
    task automatic model_run(input logic [15:0] en, input int a);
        int pos;
        int launch;
        int wl;
        pos    = 1;
        m_done = '0;
        m_tmo  = '0;
        for (int i = 0; i < 16; i++) begin
            m_launch[i] = -1;
            if (en[i]) begin
                launch = pos + 1;
                wl     = (dly[i] < T) ? dly[i] : T;
                if (a < 0 || launch <= a) m_launch[i] = launch;
                if (a < 0 || launch + wl < a) begin
                    if (dly[i] <= T) m_done[i] = 1'b1;
                    else             m_tmo[i]  = 1'b1;
                end
                pos = launch + wl + G + 1;
            end else begin
                pos = pos + 1;
            end
        end
        m_finish = pos;
    endtask

    task automatic do_run(input string name, input logic [15:0] en, input int a,
                          input int busy_start_at, input bit abort_with_start);
        int          done_at[16];
        int          end_c;
        int          last_busy;
        logic [15:0] exp_ts;
        logic [15:0] td;
        logic        exp_busy;
        logic        exp_sd;
        model_run(en, a);
        for (int i = 0; i < 16; i++) done_at[i] = -1;
        last_busy = (a >= 0) ? a : m_finish;
        end_c     = last_busy + 3;

        @(negedge clk);
        bus.enable = en;
        bus.start  = 1'b1;
        bus.abort  = abort_with_start;

        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            bus.start  = (c == busy_start_at);
            bus.abort  = (c == a);
            bus.enable = 16'($urandom);

            exp_ts = '0;
            for (int i = 0; i < 16; i++) if (m_launch[i] == c) exp_ts[i] = 1'b1;
            exp_busy = (c <= last_busy);
            exp_sd   = (a < 0) && (c == m_finish);

            checks++;
            if (bus.task_start !== exp_ts) begin
                failures++;
                $display("FAIL %s task_start cycle=%0d got=%h exp=%h", name, c, bus.task_start, exp_ts);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                failures++;
                $display("FAIL %s busy cycle=%0d got=%b exp=%b", name, c, bus.busy, exp_busy);
            end
            checks++;
            if (bus.seq_done !== exp_sd) begin
                failures++;
                $display("FAIL %s seq_done cycle=%0d got=%b exp=%b", name, c, bus.seq_done, exp_sd);
            end
            for (int i = 0; i < 16; i++) begin
                if (m_launch[i] == c) begin
                    checks++;
                    if (bus.cur_task !== 4'(i)) begin
                        failures++;
                        $display("FAIL %s cur_task cycle=%0d got=%0d exp=%0d", name, c, bus.cur_task, i);
                    end
                end
            end

            // Responder: answer each observed launch after its delay; noise
            // on tasks outside the run must be ignored by the sequencer.
            for (int i = 0; i < 16; i++) if (bus.task_start[i]) done_at[i] = c + dly[i];
            td = 16'($urandom) & ~en;
            for (int i = 0; i < 16; i++) if (done_at[i] == c) td[i] = 1'b1;
            bus.task_done = td;
        end
        bus.task_done = '0;
        bus.abort     = 1'b0;
        bus.start     = 1'b0;

        checks++;
        if (bus.done_mask !== m_done) begin
            failures++;
            $display("FAIL %s done_mask got=%h exp=%h", name, bus.done_mask, m_done);
        end
        checks++;
        if (bus.timeout_mask !== m_tmo) begin
            failures++;
            $display("FAIL %s timeout_mask got=%h exp=%h", name, bus.timeout_mask, m_tmo);
        end
        last_done = m_done;
        last_tmo  = m_tmo;
        $display("run %s en=%h abort=%0d done_mask=%h timeout_mask=%h finish=%0d",
                 name, en, a, bus.done_mask, bus.timeout_mask, m_finish);
    endtask

    task automatic test_reset();
        bus.enable    = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.task_done = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.task_start !== 16'h0) begin failures++; $display("FAIL reset task_start got=%h exp=0", bus.task_start); end
        checks++;
        if (bus.seq_done !== 1'b0) begin failures++; $display("FAIL reset seq_done got=%b exp=0", bus.seq_done); end
        checks++;
        if (bus.cur_task !== 4'd0) begin failures++; $display("FAIL reset cur_task got=%0d exp=0", bus.cur_task); end
        checks++;
        if (bus.done_mask !== 16'h0 || bus.timeout_mask !== 16'h0) begin
            failures++;
            $display("FAIL reset masks got=%h/%h exp=0/0", bus.done_mask, bus.timeout_mask);
        end
        $display("run reset done");
    endtask

    task automatic test_directed();
        for (int i = 0; i < 16; i++) dly[i] = 3;
        do_run("two_tasks", 16'h0005, -1, -1, 1'b0);
        dly[15] = 1000;
        do_run("timeout_t16", 16'h8000, -1, -1, 1'b0);
        do_run("empty_mask", 16'h0000, -1, 5, 1'b0);
        dly[0] = 8;
        do_run("abort_wait", 16'h0003, 5, -1, 1'b0);
        dly[4] = T;
        do_run("done_at_timeout", 16'h0010, -1, 6, 1'b0);
        dly[0] = 2; dly[1] = 1;
        do_run("abort_with_start", 16'h0003, -1, -1, 1'b1);
    endtask

    task automatic test_abort_idle();
        bus.abort = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_idle busy got=%b exp=0", bus.busy); end
            checks++;
            if (bus.done_mask !== last_done || bus.timeout_mask !== last_tmo) begin
                failures++;
                $display("FAIL abort_idle masks got=%h/%h exp=%h/%h",
                         bus.done_mask, bus.timeout_mask, last_done, last_tmo);
            end
        end
        bus.abort = 1'b0;
        $display("run abort_idle done");
    endtask

    task automatic test_random();
        logic [15:0] en;
        int          a;
        int          bs;
        for (int r = 0; r < 24; r++) begin
            en = 16'($urandom) & 16'($urandom);
            if (r % 8 == 7) en = '0;
            for (int i = 0; i < 16; i++) dly[i] = int'($urandom_range(1, T + 3));
            model_run(en, -1);
            a = -1;
            if ($urandom_range(0, 3) == 0) a = int'($urandom_range(1, m_finish - 1));
            bs = int'($urandom_range(1, (a >= 0) ? a : m_finish));
            do_run($sformatf("random%0d", r), en, a, bs, 1'($urandom_range(0, 1)));
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) dly[i] = 100;
        @(negedge clk);
        bus.enable = 16'h0008;
        bus.start  = 1'b1;
        repeat (8) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        // Index 3 launches in cycle 5, so cycle 8 is inside WAIT.
        checks++;
        if (bus.busy !== 1'b1 || bus.cur_task !== 4'd3) begin
            failures++;
            $display("FAIL async_reset pre busy/cur_task got=%b/%0d exp=1/3", bus.busy, bus.cur_task);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL async_reset busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.cur_task !== 4'd0) begin failures++; $display("FAIL async_reset cur_task got=%0d exp=0", bus.cur_task); end
        checks++;
        if (bus.task_start !== 16'h0 || bus.seq_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset pulses got=%h/%b exp=0/0", bus.task_start, bus.seq_done);
        end
        checks++;
        if (bus.done_mask !== 16'h0 || bus.timeout_mask !== 16'h0) begin
            failures++;
            $display("FAIL async_reset masks got=%h/%h exp=0/0", bus.done_mask, bus.timeout_mask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.task_start !== 16'h0) begin
                failures++;
                $display("FAIL post_reset idle cycle=%0d busy=%b task_start=%h exp=0/0", c, bus.busy, bus.task_start);
            end
        end
        $display("run async_reset done");
    endtask

    initial begin
        bus.enable    = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.task_done = '0;
        last_done     = '0;
        last_tmo      = '0;
        test_reset();
        test_directed();
        test_abort_idle();
        test_random();
        test_async_reset();
        for (int i = 0; i < 16; i++) dly[i] = 2;
        do_run("after_reset", 16'h0101, -1, -1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/task_sequencer.md
TASK_SEQUENCER -- requirements
Module: task_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, max cycles a launched task may run before it is declared timed out (legal range 1..2^24).
REQ-002 Parameter GAP_CYCLES, default 4, idle cycles inserted after each task completes or times out, before the next index is scanned (0 = no gap).
REQ-003 clk  input  1  single clock; all state is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  16  task enable mask, type task_enabler_pkg::task_enabler; bit 0 = task1 ... bit 15 = task16.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 abort  input  1  terminate the current run.
REQ-008 task_start  output  16  one-hot, one-cycle launch pulse to task i.
REQ-009 task_done  input  16  per-task completion pulse.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 cur_task  output  4  index of the task being scanned, launched or awaited.
REQ-012 seq_done  output  1  one-cycle pulse when a run completes normally.
REQ-013 done_mask  output  16  sticky per run; bit i set when task i completed.
REQ-014 timeout_mask  output  16  sticky per run; bit i set when task i timed out.

Function
REQ-015 FSM states: IDLE, SCAN, LAUNCH, WAIT, GAP, FINISH. All outputs are registered or decoded from registered state only.
REQ-016 IDLE + start=1: latch enable into run_mask, clear done_mask and timeout_mask, set idx=0, go to SCAN. Changes to enable during a run are ignored.
REQ-017 SCAN: if run_mask[idx]=1, go to LAUNCH. Otherwise, if idx=15, go to FINISH. Otherwise increment idx and stay in SCAN. Each index costs one cycle.
REQ-018 LAUNCH: task_start[idx]=1 for exactly one cycle, clear timer, go to WAIT. task_start is 0 in every other state.
REQ-019 WAIT: task_done[idx]=1 sets done_mask[idx] and goes to GAP. Otherwise, if timer=TIMEOUT_CYCLES-1, set timeout_mask[idx] and go to GAP. Otherwise increment timer.
REQ-020 WAIT: task_done and the timeout condition in the same cycle count as done; timeout_mask is not set.
REQ-021 task_done bits other than idx are ignored in every state. task_done in IDLE has no effect.
REQ-022 GAP: count GAP_CYCLES cycles. Then, if idx=15, go to FINISH. Otherwise increment idx and go to SCAN. With GAP_CYCLES=0, WAIT exits directly to that target.
REQ-023 FINISH: seq_done=1 for one cycle, then go to IDLE. done_mask and timeout_mask hold until the next accepted start.
REQ-024 Latency: the first enabled index k gets its task_start pulse in the (k+2)-th cycle after the cycle in which start is sampled high.
REQ-025 Empty mask: seq_done asserts 17 cycles after start with both masks 0.
REQ-026 start while busy is ignored; there is no queueing.
REQ-027 abort=1 in any non-IDLE state: go to IDLE on the next edge. No seq_done. Masks keep their partial values. abort has priority over every other transition. abort in IDLE has no effect. abort and start together in IDLE: start is accepted.
REQ-028 The timer width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.

Reset
REQ-029 rst_n=0 asynchronously forces state=IDLE, idx=0, timer=0, run_mask=0, task_start=0, busy=0, cur_task=0, seq_done=0, done_mask=0, timeout_mask=0.
REQ-030 Reset mid-run discards the run. After rst_n deasserts, no task_start issues until a new start.

Verification
REQ-031 enable=16'h0005, GAP=4, each task_done returned 3 cycles after its task_start -> task_start[0] then task_start[2]; done_mask=16'h0005; timeout_mask=0; one seq_done pulse.
REQ-032 enable=16'h8000, TIMEOUT_CYCLES=10, task_done never asserted -> WAIT lasts 10 cycles; timeout_mask=16'h8000; done_mask=0; seq_done asserted.
REQ-033 enable=0 with start -> busy high for 17 cycles, seq_done on the 17th, no task_start pulses.
REQ-034 enable=16'h0003, abort during WAIT of task1 -> IDLE next cycle, no seq_done, task_start[1] never issued, done_mask=0.
REQ-035 task_done[idx] and timeout coincide, plus start pulsed while busy -> done_mask bit set, timeout_mask bit clear, second start ignored.
REQ-036 rst_n driven low mid-WAIT, asynchronous to clk -> all outputs go to 0 immediately; after release, outputs stay idle until a new start.
